// File: rtl/ibex_regfile_checker.sv
// Shadow-copy checker for the Ibex register file.
// Snoops the write port to mirror every architectural register, then on
// request sweeps all registers two at a time through read ports A and B
// and records mismatches: sticky flag, saturating count, first-error capture.
module ibex_regfile_checker #(
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned AddrWidth   = 5,
   parameter int unsigned ErrCntWidth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   we_a_i,
   input  logic [AddrWidth-1:0]   waddr_a_i,
   input  logic [DataWidth-1:0]   wdata_a_i,
   input  logic                   start_i,
   output logic [AddrWidth-1:0]   raddr_a_o,
   output logic [AddrWidth-1:0]   raddr_b_o,
   input  logic [DataWidth-1:0]   rdata_a_i,
   input  logic [DataWidth-1:0]   rdata_b_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [ErrCntWidth-1:0] err_cnt_o,
   output logic [AddrWidth-1:0]   err_addr_o,
   output logic [DataWidth-1:0]   err_exp_o,
   output logic [DataWidth-1:0]   err_act_o
);

   localparam int unsigned NumRegs   = 2 ** AddrWidth;
   localparam int unsigned PairWidth = AddrWidth - 1;
   localparam int unsigned SumWidth  = ErrCntWidth + 1;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_e;

   state_e                 state, state_next;
   logic [PairWidth-1:0]   pair;        // register pair being swept: {pair,0} and {pair,1}
   logic [DataWidth-1:0]   shadow [NumRegs];
   logic [NumRegs-1:0]     valid;

   logic [DataWidth-1:0]   exp_a, exp_b;
   logic                   chk_a, chk_b;
   logic                   mis_a, mis_b;
   logic [SumWidth-1:0]    cnt_sum;
   logic [ErrCntWidth-1:0] cnt_next;

   // Sweep sequencing: IDLE -> SWEEP (one pair per cycle) -> DONE -> IDLE.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_next = state;
      case (state)
         IDLE:    if (start_i) state_next = SWEEP;
         SWEEP:   if (&pair)   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset abandons any sweep without a done pulse.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // Pair index: cleared on start, advanced once per sweep cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i)                         pair <= '0;
      else if (state == IDLE && start_i) pair <= '0;
      else if (state == SWEEP)           pair <= pair + PairWidth'(1);
   end

   assign busy_o    = (state == SWEEP);
   assign done_o    = (state == DONE);
   assign raddr_a_o = busy_o ? {pair, 1'b0} : '0;
   assign raddr_b_o = busy_o ? {pair, 1'b1} : '0;

   // Shadow data mirrors the register file contents; x0 is never written.
   always_ff @(posedge clk_i) begin
      // NOTE: shadow storage has no reset; the valid bits alone decide
      // whether a register's contents are meaningful.
      if (we_a_i && waddr_a_i != '0) shadow[waddr_a_i] <= wdata_a_i;
   end

   // Valid bits mark registers written since reset.
   always_ff @(posedge clk_i) begin
      if (rst_i)                          valid <= '0;
      else if (we_a_i && waddr_a_i != '0) valid[waddr_a_i] <= 1'b1;
   end

   // Per-port compare against pre-edge shadow contents; x0 always reads zero.
   always_comb begin
      exp_a = (raddr_a_o == '0) ? '0 : shadow[raddr_a_o];
      exp_b = shadow[raddr_b_o];
      chk_a = busy_o && ((raddr_a_o == '0) || valid[raddr_a_o]);
      chk_b = busy_o && valid[raddr_b_o];
      mis_a = chk_a && (rdata_a_i != exp_a);
      mis_b = chk_b && (rdata_b_i != exp_b);
   end

   // Saturating add of up to two mismatches per cycle.
   always_comb begin
      cnt_sum  = {1'b0, err_cnt_o} + SumWidth'(mis_a) + SumWidth'(mis_b);
      cnt_next = cnt_sum[ErrCntWidth] ? '1 : cnt_sum[ErrCntWidth-1:0];
   end

   // Error bookkeeping: sticky flag, count, and capture of the first mismatch
   // (port A wins when both ports fail in that cycle).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_o      <= 1'b0;
         err_cnt_o  <= '0;
         err_addr_o <= '0;
         err_exp_o  <= '0;
         err_act_o  <= '0;
      end else begin
         err_cnt_o <= cnt_next;
         if (mis_a || mis_b) begin
            err_o <= 1'b1;
            if (!err_o) begin
               if (mis_a) begin
                  err_addr_o <= raddr_a_o;
                  err_exp_o  <= exp_a;
                  err_act_o  <= rdata_a_i;
               end else begin
                  err_addr_o <= raddr_b_o;
                  err_exp_o  <= exp_b;
                  err_act_o  <= rdata_b_i;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ibex_regfile_checker.sv
// Bench for ibex_regfile_checker: a behavioural register file with
// per-register corruption feeds the read ports; sweep results are queued
// at start and compared when done_o appears.
module tb_ibex_regfile_checker;

   typedef struct {
      logic        err;
      logic [15:0] cnt;
      logic [4:0]  addr;
      logic [31:0] expv;
      logic [31:0] actv;
   } res_t;

   typedef struct {
      bit          rst_first;
      logic [31:0] mask;
      logic [31:0] x0v;
      res_t        res;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        start = 1'b0;
   logic [4:0]  raddr_a, raddr_b;
   logic [31:0] rdata_a, rdata_b;
   logic        busy, done, err;
   logic [15:0] err_cnt;
   logic [4:0]  err_addr;
   logic [31:0] err_exp, err_act;

   // Register file model and read-side corruption controls.
   logic [31:0] rf_mem [32];
   logic [31:0] corrupt_mask = '0;
   logic [31:0] x0_val = '0;
   logic        ovr_en = 1'b0;
   logic [4:0]  ovr_addr = '0;
   logic [31:0] ovr_val = '0;

   int   errors = 0;
   int   checks = 0;
   res_t sb[$];
   vec_t vecs[6];

   ibex_regfile_checker dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_a_i     (we),
      .waddr_a_i  (waddr),
      .wdata_a_i  (wdata),
      .start_i    (start),
      .raddr_a_o  (raddr_a),
      .raddr_b_o  (raddr_b),
      .rdata_a_i  (rdata_a),
      .rdata_b_i  (rdata_b),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .err_cnt_o  (err_cnt),
      .err_addr_o (err_addr),
      .err_exp_o  (err_exp),
      .err_act_o  (err_act)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we && waddr != 5'd0) rf_mem[waddr] <= wdata;
   end

   always_comb begin
      rdata_a = (raddr_a == 5'd0) ? x0_val : (rf_mem[raddr_a] ^ {31'b0, corrupt_mask[raddr_a]});
      rdata_b = (raddr_b == 5'd0) ? x0_val : (rf_mem[raddr_b] ^ {31'b0, corrupt_mask[raddr_b]});
      if (ovr_en && raddr_a == ovr_addr) rdata_a = ovr_val;
      if (ovr_en && raddr_b == ovr_addr) rdata_b = ovr_val;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; waddr = a; wdata = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic base_writes();
      write_reg(5'd0, 32'hDEADBEEF);
      write_reg(5'd1, 32'h0F0F0F0F);
      write_reg(5'd2, 32'hF0F0F0F0);
      write_reg(5'd4, 32'h44444444);
      write_reg(5'd5, 32'h55555555);
   endtask

   // Launch one sweep, push its expected result, watch 24 cycles.
   task automatic run_sweep(input res_t e, input bit spam, input int wr_at, input logic [31:0] wr_data);
      int   nb = 0;
      int   nd = 0;
      bit   wrote = 1'b0;
      res_t r;
      sb.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (busy) nb++;
         if (done) begin
            nd++;
            if (sb.size() > 0) begin
               r = sb.pop_front();
               check("err_o", 32'(err), 32'(r.err));
               check("err_cnt_o", 32'(err_cnt), 32'(r.cnt));
               check("err_addr_o", 32'(err_addr), 32'(r.addr));
               check("err_exp_o", err_exp, r.expv);
               check("err_act_o", err_act, r.actv);
            end
         end
         start = spam && (busy || done);
         if (!wrote && busy && wr_at >= 0 && raddr_a == wr_at[4:0]) begin
            we = 1'b1; waddr = wr_at[4:0]; wdata = wr_data; wrote = 1'b1;
         end else begin
            we = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      we = 1'b0;
      check("busy_cycles", 32'(nb), 32'd16);
      check("done_pulses", 32'(nd), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      res_t none;
      int   nd;
      none = '{1'b0, 16'd0, 5'd0, 32'h0, 32'h0};

      vecs[0] = '{1'b1, 32'h0, 32'h0, none};
      vecs[1] = '{1'b0, 32'h0000_0004, 32'h0, '{1'b1, 16'd1, 5'd2, 32'hF0F0F0F0, 32'hF0F0F0F1}};
      vecs[2] = '{1'b1, 32'h0000_0030, 32'h1, '{1'b1, 16'd3, 5'd0, 32'h0, 32'h1}};
      vecs[3] = '{1'b0, 32'h0000_0030, 32'h1, '{1'b1, 16'd6, 5'd0, 32'h0, 32'h1}};
      vecs[4] = '{1'b1, 32'h8000_0008, 32'h0, none};
      vecs[5] = '{1'b1, 32'h0000_0002, 32'h0, '{1'b1, 16'd1, 5'd1, 32'h0F0F0F0F, 32'h0F0F0F0E}};

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_cnt", 32'(err_cnt), 32'd0);
      check("rst_addr", 32'(err_addr), 32'd0);
      check("rst_exp", err_exp, 32'h0);
      check("rst_act", err_act, 32'h0);
      check("rst_raddr_a", 32'(raddr_a), 32'd0);
      check("rst_raddr_b", 32'(raddr_b), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // No writes: every register but x0 corrupted, none checked.
      corrupt_mask = 32'hFFFF_FFFE;
      run_sweep(none, 1'b0, -1, 32'h0);

      // Table of sweep scenarios.
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].rst_first) begin
            do_reset();
            base_writes();
         end
         corrupt_mask = vecs[i].mask;
         x0_val       = vecs[i].x0v;
         run_sweep(vecs[i].res, 1'b0, -1, 32'h0);
      end

      // Reset in sweep cycle 5 (error state from the last vector is live).
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_raddr_a", 32'(raddr_a), 32'd8);
      check("mid_raddr_b", 32'(raddr_b), 32'd9);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_err", 32'(err), 32'd0);
      check("mrst_cnt", 32'(err_cnt), 32'd0);
      check("mrst_addr", 32'(err_addr), 32'd0);
      check("mrst_exp", err_exp, 32'h0);
      check("mrst_act", err_act, 32'h0);
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) nd++;
         @(negedge clk);
      end
      check("mrst_no_done", 32'(nd), 32'd0);

      // Valid bits were cleared (x1 still corrupted) and repeated starts
      // while busy/done are ignored.
      run_sweep(none, 1'b1, -1, 32'h0);

      // Same-cycle write to the register being swept.
      do_reset();
      corrupt_mask = '0;
      x0_val       = '0;
      write_reg(5'd6, 32'h12345678);
      run_sweep(none, 1'b0, 6, 32'hAAAA5555);
      run_sweep(none, 1'b0, -1, 32'h0);
      ovr_en   = 1'b1;
      ovr_addr = 5'd6;
      ovr_val  = 32'h12345678;
      run_sweep('{1'b1, 16'd1, 5'd6, 32'hAAAA5555, 32'h12345678}, 1'b0, -1, 32'h0);
      ovr_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
